// File: rtl/fnv_pkg.sv
// FNV-1a 32-bit shared constants and checker state encoding.
// Also parameterises the sender-side hash block.
package fnv_pkg;

    localparam logic [31:0] FNV32_OFFSET_BASIS = 32'h811C9DC5;
    localparam logic [31:0] FNV32_PRIME        = 32'h01000193;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ABSORB = 2'd1;
    localparam logic [1:0] ST_MIX    = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

endpackage

// File: rtl/fnv32_mul_prime.sv
// Combinational 32-bit multiply by a constant prime, built from shifts and adds.
// Only the set bits of PRIME produce adders, so no hard multiplier is inferred.
module fnv32_mul_prime
    import fnv_pkg::*;
#(
    parameter logic [31:0] PRIME = FNV32_PRIME
) (
    input  logic [31:0] h,
    output logic [31:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (PRIME[i]) begin
                p = p + (h << i);
            end
        end
    end

endmodule

// File: rtl/fnv_1a_32_check.sv
// Byte-serial FNV-1a 32-bit digest checker: absorbs octets over valid/ready,
// then compares the digest with an expected value and reports the verdict.
module fnv_1a_32_check
    import fnv_pkg::*;
#(
    parameter logic [31:0] OFFSET_BASIS = FNV32_OFFSET_BASIS,
    parameter logic [31:0] FNV_PRIME    = FNV32_PRIME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        finish,
    input  logic [31:0] expected,
    output logic [31:0] digest,
    output logic        done,
    output logic        match,
    output logic        busy
);

    logic [1:0]  state;
    logic [31:0] hash;
    logic [31:0] hash_mul;
    logic        match_q;
    logic        pend;
    logic        hs;

    assign hs = in_valid && in_ready;

    fnv32_mul_prime #(
        .PRIME(FNV_PRIME)
    ) u_mul (
        .h(hash),
        .p(hash_mul)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            hash    <= OFFSET_BASIS;
            match_q <= 1'b0;
            pend    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        hash    <= OFFSET_BASIS;
                        match_q <= 1'b0;
                        pend    <= 1'b0;
                        state   <= ST_ABSORB;
                    end
                end
                ST_ABSORB: begin
                    if (hs) begin
                        hash  <= hash ^ {24'h0, in_data};
                        pend  <= finish;
                        state <= ST_MIX;
                    end else if (finish) begin
                        state <= ST_CHECK;
                    end
                end
                ST_MIX: begin
                    hash <= hash_mul;
                    // a finish seen while mixing is remembered, never queued twice
                    if (pend || finish) begin
                        pend  <= 1'b1;
                        state <= ST_CHECK;
                    end else begin
                        state <= ST_ABSORB;
                    end
                end
                ST_CHECK: begin
                    match_q <= (hash == expected);
                    pend    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == ST_ABSORB);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_CHECK);
    assign digest   = hash;
    // verdict is live during the done cycle, then held until next start
    assign match    = done ? (hash == expected) : match_q;

endmodule

// File: tb/tb_fnv_1a_32_check.sv
// Scoreboard bench for fnv_1a_32_check: directed vectors, reset abort,
// protocol abuse and randomized messages against an arithmetic FNV-1a model.
module tb_fnv_1a_32_check;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        finish;
    logic [31:0] expected;
    logic [31:0] digest;
    logic        done;
    logic        match;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dig;
        logic        m;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fnv_1a_32_check dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .finish(finish),
        .expected(expected),
        .digest(digest),
        .done(done),
        .match(match),
        .busy(busy)
    );

    function automatic logic [31:0] ref_fnv(input logic [7:0] msg[$]);
        logic [31:0] h;
        h = 32'h811C9DC5;
        foreach (msg[i]) begin
            h = h ^ {24'h0, msg[i]};
            h = h * 32'h01000193;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every done pulse must match the oldest outstanding message
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("sb_digest", digest, e.dig);
                    chk("sb_match", {31'h0, match}, {31'h0, e.m});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input logic [31:0] exp_in,
                            input bit fin_last, input bit gaps, input bit abuse);
        logic [31:0] model;
        int          lat;
        bit          last;
        model = ref_fnv(msg);
        expected = exp_in;
        sb.push_back('{dig: model, m: (model == exp_in)});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'h0, busy}, 32'd1);
        foreach (msg[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            wait_ready();
            last = (i == msg.size() - 1);
            in_data  = msg[i];
            in_valid = 1'b1;
            if (abuse) start = 1'b1;
            if (last && fin_last) finish = 1'b1;
            tick();
            in_valid = 1'b0;
            finish   = 1'b0;
            start    = 1'b0;
            in_data  = 8'($urandom);
            chk("ready_low_in_mix", {31'h0, in_ready}, 32'd0);
        end
        lat = 1;
        if (fin_last && msg.size() > 0) begin
            if (abuse) begin
                finish = 1'b1;
                tick();
                finish = 1'b0;
                lat++;
            end
        end else begin
            wait_ready();
            finish = 1'b1;
            tick();
            finish = 1'b0;
        end
        while (done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk("verdict_latency", lat,
            (fin_last && msg.size() > 0) ? 32'd2 : 32'd1);
        tick();
        chk("done_one_cycle", {31'h0, done}, 32'd0);
        chk("idle_after_check", {31'h0, busy}, 32'd0);
        chk("digest_held", digest, model);
        chk("match_held", {31'h0, match}, {31'h0, (model == exp_in)});
        if (abuse) begin
            finish   = 1'b1;
            in_valid = 1'b1;
            tick();
            tick();
            finish   = 1'b0;
            in_valid = 1'b0;
            chk("idle_ignores_finish", {31'h0, busy}, 32'd0);
            chk("idle_ready_low", {31'h0, in_ready}, 32'd0);
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] m;
        logic [31:0] e;
        int          len;
        bit          fl;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        finish   = 1'b0;
        in_data  = 8'h00;
        expected = 32'h0;
        repeat (3) tick();
        chk("rst_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_match", {31'h0, match}, 32'd0);
        chk("rst_digest", digest, 32'h811C9DC5);
        reset = 1'b0;
        tick();

        q = {};
        send_msg(q, 32'h811C9DC5, 1'b0, 1'b0, 1'b0);
        q = {8'h61};
        send_msg(q, 32'hE40C292C, 1'b1, 1'b0, 1'b0);
        q = {8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
        send_msg(q, 32'hBF9CF968, 1'b0, 1'b0, 1'b0);
        send_msg(q, 32'hBF9CF969, 1'b0, 1'b0, 1'b0);

        // abort mid-message with reset while the hash is mixing
        start = 1'b1;
        tick();
        start = 1'b0;
        in_data  = 8'h66;
        in_valid = 1'b1;
        tick();
        in_data  = 8'h6F;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_in_mix", {31'h0, in_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_ready", {31'h0, in_ready}, 32'd0);
        chk("reset_mid_busy", {31'h0, busy}, 32'd0);
        chk("reset_mid_digest", digest, 32'h811C9DC5);
        chk("reset_mid_match", {31'h0, match}, 32'd0);
        q = {8'h61};
        send_msg(q, 32'hE40C292C, 1'b1, 1'b0, 1'b0);

        q = {8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
        send_msg(q, 32'hBF9CF968, 1'b1, 1'b1, 1'b1);

        for (int k = 0; k < 25; k++) begin
            len = $urandom_range(0, 10);
            q = {};
            for (int j = 0; j < len; j++) q.push_back(8'($urandom));
            m = ref_fnv(q);
            e = m;
            if ($urandom_range(0, 3) == 0) e = m ^ (32'h1 << $urandom_range(0, 31));
            fl = (len > 0) && ($urandom_range(0, 1) == 1);
            send_msg(q, e, fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnv_1a_32_check.md
Name: fnv_1a_32_check

Overview:
- Byte-serial FNV-1a 32-bit digest checker: the receive end of the I2C peripheral's message-integrity path.
- Consumes a message one octet at a time over a valid/ready handshake and computes the digest.
- On finish, compares the digest against an expected value and reports pass/fail.
- Sits between the I2C byte receiver and the register file. Sender-side digests come from the existing hash block.

Parameters:
- OFFSET_BASIS, 32'h811C9DC5, initial hash value.
- FNV_PRIME, 32'h01000193, multiplier (product truncated to 32 bits).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  pulse: initialise hash, begin new message
- in_data  input  8  message octet
- in_valid  input  1  octet present
- in_ready  output  1  octet accepted when in_valid && in_ready
- finish  input  1  pulse: message complete
- expected  input  32  reference digest, sampled in CHECK
- digest  output  32  current/final hash register
- done  output  1  one-cycle pulse when verdict is valid
- match  output  1  verdict: digest == expected, held until next start
- busy  output  1  high in any state except IDLE

Behaviour:
- States: IDLE, ABSORB, MIX, CHECK.
- Reset, from any state, mid-message included:
  - state=IDLE, hash=OFFSET_BASIS.
  - in_ready=0, done=0, match=0, busy=0, pending-finish flag cleared.
- IDLE:
  - in_ready=0; in_valid and finish are ignored.
  - start -> hash=OFFSET_BASIS, match=0, go to ABSORB next cycle.
- ABSORB:
  - in_ready=1.
  - Handshake -> hash = hash ^ {24'b0, in_data}, go to MIX.
  - finish without handshake -> go to CHECK.
  - finish with handshake in the same cycle -> absorb the byte, set pending-finish, go to MIX.
- MIX:
  - in_ready=0; hash = hash * FNV_PRIME mod 2^32.
  - Implement as shift-add: (h<<24)+(h<<8)+(h<<7)+(h<<4)+(h<<1)+h. No DSP multiplier.
  - Next state: CHECK if pending-finish, else ABSORB.
  - A finish arriving during MIX sets pending-finish.
- CHECK:
  - in_ready=0; match = (hash == expected); done=1 for this single cycle; go to IDLE.
  - expected must be stable in this cycle.
- Throughput: one octet per 2 cycles. Verdict is reached 1 cycle (finish in ABSORB) or 2 cycles (finish with the last byte) after the finish cycle.
- Zero-length message: start then finish -> digest=OFFSET_BASIS.
- start is honoured only in IDLE; ignored while busy (no abort, use reset).
- finish pulses are not queued beyond one: a second finish before CHECK is ignored.
- digest is a direct view of the hash register and remains valid after done until the next start.
- in_data must be stable only during the handshake cycle.

Decomposition:
- Shared package fnv_pkg:
  - FNV32_OFFSET_BASIS and FNV32_PRIME constants.
  - State enum encoding (2 bits).
  - The same constants also parameterise the existing hash block.
- One natural sub-module: fnv32_mul_prime, a combinational 32-bit multiply-by-prime shift-add. Reusable by the hash block.

Test Plan:
- Empty message: start, finish, expected=32'h811C9DC5 -> done pulse 1 cycle after finish; match=1; digest=32'h811C9DC5.
- Single byte "a": start, send 8'h61 with finish in the same cycle, expected=32'hE40C292C -> in_ready low for 1 cycle; done 2 cycles after finish; match=1.
- "foobar" (66 6F 6F 62 61 72), back-to-back valid, finish after last handshake, expected=32'hBF9CF968 -> in_ready toggles 1,0 per byte; match=1; digest=32'hBF9CF968.
- Same "foobar" with expected=32'hBF9CF969 -> done=1, match=0, digest unchanged.
- Reset asserted in MIX mid-"foobar" -> next cycle state IDLE, in_ready=0, busy=0; then a fresh "a" message -> match against 32'hE40C292C.
- Protocol abuse: start while busy, finish in IDLE, in_valid in IDLE -> all ignored; second finish before CHECK -> single done pulse only.
